// File: rtl/video_pkg.sv
// Shared types and constants for the video fetch responder.
package video_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  // Bus-cycle phase in which video reads are accepted by default.
  localparam logic [1:0] VIDEO_SLOT_DEF = 2'd0;

  // Word value substituted when the RAM never acknowledges.
  localparam logic [15:0] TIMEOUT_FILL = 16'hFFFF;

  // Place a 16-bit word into its slot of the 64-bit assembly word;
  // slot 0 is the most significant.
  function automatic logic [63:0] put_word(input logic [63:0] asm,
                                           input logic [1:0]  idx,
                                           input logic [15:0] w);
    logic [63:0] r;
    r = asm;
    case (idx)
      2'd0:    r[63:48] = w;
      2'd1:    r[47:32] = w;
      2'd2:    r[31:16] = w;
      default: r[15:0]  = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/video_fetch_responder.sv
// Memory-side responder for the video fetch bus: on an accepted video read,
// fetches four consecutive 16-bit RAM words and presents them as one 64-bit word.
module video_fetch_responder
  import video_pkg::*;
#(
  parameter logic [1:0]  VIDEO_SLOT = VIDEO_SLOT_DEF,
  parameter int unsigned TIMEOUT    = 24,
  parameter int unsigned TO_W       = 5
) (
  input  logic        clk_32,
  input  logic        reset,
  input  logic        clk_8_en,
  input  logic [1:0]  bus_cycle,
  input  logic [22:0] vaddr,
  input  logic        read,
  output logic [63:0] data,
  output logic        data_valid,
  output logic        busy,
  output logic        overrun,
  output logic [22:0] ram_addr,
  output logic        ram_rd,
  input  logic [15:0] ram_din,
  input  logic        ram_ack
);

  state_t          state_q;
  logic [22:0]     base_q;
  logic [1:0]      idx_q;
  logic [TO_W-1:0] cnt_q;
  logic [63:0]     asm_q;
  logic [63:0]     data_q;
  logic            data_valid_q;
  logic            busy_q;
  logic            overrun_q;
  logic [22:0]     ram_addr_q;
  logic            ram_rd_q;

  logic            req_hit;
  logic            expire;
  logic [15:0]     word_d;
  logic [63:0]     asm_d;

  // Request decode, timeout detect and next assembly word.
  always_comb begin
    req_hit = clk_8_en && (bus_cycle == VIDEO_SLOT) && read;
    expire  = (cnt_q == TO_W'(TIMEOUT - 1));
    word_d  = ram_ack ? ram_din : TIMEOUT_FILL;
    asm_d   = put_word(asm_q, idx_q, word_d);
  end

  // Fetch sequencer with registered outputs.
  // data and its strobe are loaded on the transition into DONE so that both
  // are visible together for the single DONE cycle.
  always_ff @(posedge clk_32 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      base_q       <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      asm_q        <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      ram_addr_q   <= '0;
      ram_rd_q     <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      if (req_hit && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (req_hit) begin
            base_q  <= vaddr;
            busy_q  <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          ram_addr_q <= base_q + {21'b0, idx_q};
          ram_rd_q   <= 1'b1;
          cnt_q      <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (ram_ack || expire) begin
            asm_q    <= asm_d;
            ram_rd_q <= 1'b0;
            if (idx_q == 2'd3) begin
              data_q       <= asm_d;
              data_valid_q <= 1'b1;
              state_q      <= DONE;
            end else begin
              idx_q   <= idx_q + 2'd1;
              state_q <= REQ;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          idx_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign ram_addr   = ram_addr_q;
  assign ram_rd     = ram_rd_q;

endmodule
